// File: rtl/trig_accept_ctrl_pkg.sv
// trig_accept_ctrl_pkg: shared FSM state type and default sizing for the trigger acceptance block
package trig_accept_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF, FULL} state_t;
    localparam int DEF_MAX_OUTSTANDING = 8;
    localparam int DEF_CNT_WIDTH = 24;
endpackage

// File: rtl/trig_occupancy_cnt.sv
// trig_occupancy_cnt: accepted-but-unread waveform count, saturating at 0 and MAX_OUTSTANDING
module trig_occupancy_cnt
    import trig_accept_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          adc_clk,
    input  logic          reset_clk_adc,
    input  logic          inc,
    input  logic          dec,
    output logic [OW-1:0] count,
    output logic [OW-1:0] count_nxt
);
    localparam logic [OW-1:0] MAX_V = OW'(MAX_OUTSTANDING);
    logic inc_ok, dec_ok;
    assign inc_ok = inc && count != MAX_V;
    assign dec_ok = dec && count != '0;
    // next occupancy is exported so the FSM can react in the same cycle the count moves
    always_comb count_nxt = (inc_ok && !dec_ok) ? count + 1'b1 : (dec_ok && !inc_ok) ? count - 1'b1 : count;
    // occupancy register
    always_ff @(posedge adc_clk) count <= reset_clk_adc ? '0 : count_nxt;
endmodule

// File: rtl/trig_accept_ctrl.sv
// trig_accept_ctrl: trigger accept/reject FSM with holdoff and occupancy limit; TRIG_ACCEPT_CNT_EN adds event counters
module trig_accept_ctrl
    import trig_accept_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 adc_clk,
    input  logic                 reset_clk_adc,
    input  logic                 cbuf_trig_en,
    input  logic                 raw_trig,
    input  logic [15:0]          holdoff_clks,
    input  logic                 wf_done,
    output logic                 trig_pulse,
    output logic                 trig_rejected,
    output logic                 trig_busy,
    output logic [OW-1:0]        outstanding,
    output logic [CNT_WIDTH-1:0] accept_cnt,
    output logic [CNT_WIDTH-1:0] reject_cnt
);
    localparam logic [OW-1:0] MAX_V = OW'(MAX_OUTSTANDING);
    state_t state, state_nxt;
    logic [15:0] hold_cnt, hold_cnt_nxt;
    logic [OW-1:0] occ_nxt;
    logic raw_q, trig_edge, accept, reject;

    assign trig_edge = raw_trig && !raw_q;
    // occ_nxt already includes a pending trig_pulse, so an accept can never overflow
    assign accept = trig_edge && cbuf_trig_en && state == ARMED && occ_nxt < MAX_V;
    assign reject = trig_edge && cbuf_trig_en && !accept;
    assign trig_busy = state != ARMED;

    trig_occupancy_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_occ (
        .adc_clk       (adc_clk),
        .reset_clk_adc (reset_clk_adc),
        .inc           (trig_pulse),
        .dec           (wf_done),
        .count         (outstanding),
        .count_nxt     (occ_nxt)
    );

    // next state and holdoff countdown; disabling triggers drops to IDLE from anywhere
    always_comb begin
        state_nxt = state;
        hold_cnt_nxt = hold_cnt;
        if (!cbuf_trig_en) begin
            state_nxt = IDLE;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: state_nxt = ARMED;
                ARMED: begin
                    if (accept) begin
                        hold_cnt_nxt = holdoff_clks;
                        state_nxt = (holdoff_clks == '0) ? ARMED : HOLDOFF;
                    end else if (occ_nxt == MAX_V) begin
                        state_nxt = FULL;
                    end
                end
                HOLDOFF: begin
                    hold_cnt_nxt = hold_cnt - 1'b1;
                    if (hold_cnt <= 16'd1) state_nxt = (occ_nxt == MAX_V) ? FULL : ARMED;
                end
                FULL: if (occ_nxt < MAX_V) state_nxt = ARMED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // state, edge-detect history and the registered one-cycle-latency pulses
    always_ff @(posedge adc_clk) begin
        if (reset_clk_adc) begin
            state <= IDLE;
            hold_cnt <= '0;
            raw_q <= 1'b0;
            trig_pulse <= 1'b0;
            trig_rejected <= 1'b0;
        end else begin
            state <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            raw_q <= raw_trig;
            trig_pulse <= accept;
            trig_rejected <= reject;
        end
    end

`ifdef TRIG_ACCEPT_CNT_EN
    // free-running event counters, wrapping naturally at 2^CNT_WIDTH
    always_ff @(posedge adc_clk) begin
        if (reset_clk_adc) begin
            accept_cnt <= '0;
            reject_cnt <= '0;
        end else begin
            if (trig_pulse) accept_cnt <= accept_cnt + 1'b1;
            if (trig_rejected) reject_cnt <= reject_cnt + 1'b1;
        end
    end
`else
    assign accept_cnt = '0;
    assign reject_cnt = '0;
`endif
endmodule

// File: doc/trig_accept_ctrl.md
TRIG_ACCEPT_CTRL -- requirements
Module: trig_accept_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8: maximum accepted-but-unread waveforms; must not exceed trigger-address FIFO depth.
REQ-002 SHALL have parameter CNT_WIDTH, default 24: width of the accept and reject counters.
REQ-003 SHALL have port adc_clk, input, 1 bit: the single clock; everything is synchronous to its rising edge.
REQ-004 SHALL have port reset_clk_adc, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cbuf_trig_en, input, 1 bit: triggering of new waveforms is enabled.
REQ-006 SHALL have port raw_trig, input, 1 bit: raw self-trigger level/pulse.
REQ-007 SHALL have port holdoff_clks, input, 16 bits: adc_clk cycles of dead time after each accept.
REQ-008 SHALL have port wf_done, input, 1 bit: single-cycle pulse when readout of one waveform completes.
REQ-009 SHALL have port trig_pulse, output, 1 bit: single-cycle accepted trigger, drives the trigger FIFO wr_en.
REQ-010 SHALL have port trig_rejected, output, 1 bit: single-cycle pulse for a dropped trigger edge.
REQ-011 SHALL have port trig_busy, output, 1 bit: high in every state except ARMED.
REQ-012 SHALL have port outstanding, output, $clog2(MAX_OUTSTANDING+1) bits: current unread-waveform count.
REQ-013 SHALL have port accept_cnt, output, CNT_WIDTH bits: total accepted triggers.
REQ-014 SHALL have port reject_cnt, output, CNT_WIDTH bits: total rejected trigger edges.

Function
REQ-015 SHALL detect a trigger edge as raw_trig high this cycle and low the previous cycle; a held-high raw_trig SHALL produce one edge only.
REQ-016 SHALL implement states IDLE, ARMED, HOLDOFF and FULL.
REQ-017 IDLE SHALL go to ARMED when cbuf_trig_en=1.
REQ-018 Any state SHALL go to IDLE on the cycle after cbuf_trig_en=0; any holdoff count in progress SHALL be cleared and outstanding SHALL be kept.
REQ-019 In ARMED, an edge with outstanding<MAX_OUTSTANDING SHALL be accepted: trig_pulse high on the cycle after the edge cycle (1-cycle latency).
REQ-020 After an accept the FSM SHALL go to HOLDOFF with holdoff_clks loaded; the value is sampled at accept time.
REQ-021 HOLDOFF SHALL last exactly holdoff_clks cycles, then go to FULL if outstanding==MAX_OUTSTANDING, otherwise ARMED; holdoff_clks=0 SHALL give a direct transition to ARMED/FULL.
REQ-022 FULL SHALL go to ARMED on the cycle after outstanding drops below MAX_OUTSTANDING.
REQ-023 An edge arriving in IDLE, HOLDOFF or FULL SHALL assert trig_rejected with the same 1-cycle latency; an edge in IDLE SHALL be counted only if cbuf_trig_en=1.
REQ-024 outstanding SHALL increment on trig_pulse and decrement on wf_done; both in the same cycle SHALL leave it unchanged.
REQ-025 wf_done with outstanding=0 SHALL be ignored (no underflow).
REQ-026 An accept SHALL never occur at outstanding==MAX_OUTSTANDING (no overflow).
REQ-027 accept_cnt and reject_cnt SHALL increment by one per event and wrap modulo 2^CNT_WIDTH.
REQ-028 trig_pulse and trig_rejected SHALL never both be high in the same cycle.

Reset
REQ-029 On reset_clk_adc=1 at a clock edge, the block SHALL enter IDLE with trig_pulse=0, trig_rejected=0, trig_busy=1, outstanding=0, accept_cnt=0, reject_cnt=0, and the edge-detect register=0.
REQ-030 Reset SHALL take priority over every other input, including mid-HOLDOFF and coincident with a trigger edge; no pulse SHALL be emitted in the reset cycle or the cycle after it.

Configuration
REQ-031 With macro TRIG_ACCEPT_CNT_EN defined, accept_cnt and reject_cnt SHALL be implemented per REQ-027.
REQ-032 Without TRIG_ACCEPT_CNT_EN, accept_cnt and reject_cnt SHALL be tied to 0 with no counter flops, and all other behaviour SHALL be identical.

Structure
REQ-033 A shared package SHALL hold the state enumeration type (IDLE, ARMED, HOLDOFF, FULL) and the default constants MAX_OUTSTANDING=8 and CNT_WIDTH=24.
REQ-034 The outstanding up/down counter with saturation guards SHALL be a sub-module named trig_occupancy_cnt; the FSM, holdoff timer and event counters SHALL stay in the top module.

Verification
REQ-035 Enable, holdoff_clks=10, single raw_trig edge -> one trig_pulse one cycle later; accept_cnt=1; trig_busy high 10 cycles, then low.
REQ-036 holdoff_clks=10, second edge 5 cycles after the first accept -> trig_rejected pulse, reject_cnt=1, no trig_pulse; an edge at 11 cycles -> accepted.
REQ-037 MAX_OUTSTANDING=8, holdoff_clks=0, 9 spaced edges with no wf_done -> 8 accepts, ninth rejected, state FULL; one wf_done -> ARMED next cycle and the next edge is accepted.
REQ-038 outstanding=3, trig_pulse and wf_done in the same cycle -> outstanding stays 3; wf_done at outstanding=0 -> stays 0.
REQ-039 raw_trig held high 100 cycles -> exactly one accept; reset asserted mid-HOLDOFF -> IDLE, all outputs per REQ-029, no pulse.
REQ-040 Build without TRIG_ACCEPT_CNT_EN, rerun REQ-035 and REQ-036 -> identical pulse behaviour with accept_cnt=reject_cnt=0 throughout.
